// File: rtl/ddfs_pkg.sv
// Shared types and constants for the DDFS sweep blocks.
package ddfs_pkg;

    localparam int unsigned DDFS_FREQ_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        DONE  = 2'd2
    } sweep_state_t;

    typedef enum logic {
        ONE_SHOT   = 1'b0,
        CONTINUOUS = 1'b1
    } sweep_mode_t;

endpackage

// File: rtl/freq_sweep_controller.sv
// Frequency-sweep sequencer driving the DDFS control word; start/stop/step/dwell latched on i_start.
// Define SWEEP_DOWN_EN to add the i_direction input for downward sweeps.
module freq_sweep_controller
    import ddfs_pkg::*;
#(
    parameter int unsigned FREQ_WIDTH  = DDFS_FREQ_WIDTH,
    parameter int unsigned DWELL_WIDTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic                   i_abort,
    input  logic                   i_mode,
    input  logic [FREQ_WIDTH-1:0]  i_start_freq,
    input  logic [FREQ_WIDTH-1:0]  i_stop_freq,
    input  logic [FREQ_WIDTH-1:0]  i_step,
    input  logic [DWELL_WIDTH-1:0] i_dwell_cycles,
`ifdef SWEEP_DOWN_EN
    input  logic                   i_direction,
`endif
    output logic [FREQ_WIDTH-1:0]  o_freq_control,
    output logic                   o_freq_valid,
    output logic                   o_step_strobe,
    output logic                   o_busy,
    output logic                   o_done
);

    sweep_state_t           state_q, state_d;
    sweep_mode_t            mode_q, mode_d;
    logic [FREQ_WIDTH-1:0]  start_q, start_d;
    logic [FREQ_WIDTH-1:0]  stop_q, stop_d;
    logic [FREQ_WIDTH-1:0]  step_q, step_d;
    logic [DWELL_WIDTH-1:0] dwell_m1_q, dwell_m1_d;
    logic [DWELL_WIDTH-1:0] cnt_q, cnt_d;
    logic [FREQ_WIDTH-1:0]  cur_q, cur_d;
    logic                   valid_q, valid_d;
    logic                   strobe_q, strobe_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
`ifdef SWEEP_DOWN_EN
    logic                   dir_q, dir_d;
`endif

    logic [FREQ_WIDTH:0]    next_full;
    logic [FREQ_WIDTH-1:0]  next_freq;
    logic                   end_of_sweep;

    // Next point is computed one bit wider so carry/borrow out of the word ends the sweep.
    always_comb begin
        next_full = {1'b0, cur_q} + {1'b0, step_q};
        next_freq = next_full[FREQ_WIDTH-1:0];
        end_of_sweep = next_full[FREQ_WIDTH] || (next_freq > stop_q) || (step_q == '0);
`ifdef SWEEP_DOWN_EN
        if (dir_q) begin
            next_full = {1'b0, cur_q} - {1'b0, step_q};
            next_freq = next_full[FREQ_WIDTH-1:0];
            end_of_sweep = next_full[FREQ_WIDTH] || (next_freq < stop_q) || (step_q == '0);
        end
`endif
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        start_d    = start_q;
        stop_d     = stop_q;
        step_d     = step_q;
        dwell_m1_d = dwell_m1_q;
        cnt_d      = cnt_q;
        cur_d      = cur_q;
        valid_d    = valid_q;
        busy_d     = busy_q;
        strobe_d   = 1'b0;
        done_d     = 1'b0;
`ifdef SWEEP_DOWN_EN
        dir_d      = dir_q;
`endif

        case (state_q)
            IDLE: begin
                if (i_start && !i_abort) begin
                    state_d    = DWELL;
                    mode_d     = sweep_mode_t'(i_mode);
                    start_d    = i_start_freq;
                    stop_d     = i_stop_freq;
                    step_d     = i_step;
                    // Counter holds remaining cycles minus one; a dwell of 0 behaves as 1.
                    dwell_m1_d = (i_dwell_cycles == '0) ? '0 : i_dwell_cycles - DWELL_WIDTH'(1);
                    cnt_d      = dwell_m1_d;
                    cur_d      = i_start_freq;
                    valid_d    = 1'b1;
                    busy_d     = 1'b1;
                    strobe_d   = 1'b1;
`ifdef SWEEP_DOWN_EN
                    dir_d      = i_direction;
`endif
                end
            end

            DWELL: begin
                if (i_abort) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - DWELL_WIDTH'(1);
                end else if (!end_of_sweep) begin
                    cur_d    = next_freq;
                    cnt_d    = dwell_m1_q;
                    strobe_d = 1'b1;
                end else if (mode_q == CONTINUOUS) begin
                    cur_d    = start_q;
                    cnt_d    = dwell_m1_q;
                    strobe_d = 1'b1;
                    done_d   = 1'b1;
                end else begin
                    state_d = DONE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            mode_q     <= ONE_SHOT;
            start_q    <= '0;
            stop_q     <= '0;
            step_q     <= '0;
            dwell_m1_q <= '0;
            cnt_q      <= '0;
            cur_q      <= '0;
            valid_q    <= 1'b0;
            strobe_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef SWEEP_DOWN_EN
            dir_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
            step_q     <= step_d;
            dwell_m1_q <= dwell_m1_d;
            cnt_q      <= cnt_d;
            cur_q      <= cur_d;
            valid_q    <= valid_d;
            strobe_q   <= strobe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef SWEEP_DOWN_EN
            dir_q      <= dir_d;
`endif
        end
    end

    assign o_freq_control = cur_q;
    assign o_freq_valid   = valid_q;
    assign o_step_strobe  = strobe_q;
    assign o_busy         = busy_q;
    assign o_done         = done_q;

endmodule
